note_scheduler: RTL and testbench

//  Game-side scheduler for the rhythm game top (main). Fetches a note pattern from ROM and spawns arrows into 4 lanes.

---
 rtl/note_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_note_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: spawns ROM-patterned arrows into 4 lanes, advances them per frame,
// judges button presses against the hit window and keeps score/combo.
module note_scheduler #(
   parameter int  SLOTS   = 8,
   parameter int  Y_W     = 10,
   parameter int  SPEED   = 4,
   parameter int  HIT_Y   = 400,
   parameter int  HIT_WIN = 16,
   parameter int  PAT_AW  = 6,
   localparam int IW      = $clog2(SLOTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              frame_tick,
   input  logic [3:0]        btn,
   output logic [PAT_AW-1:0] pat_addr,
   input  logic [7:0]        pat_data,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic [1:0]        rd_lane,
   output logic [Y_W-1:0]    rd_y,
   output logic [15:0]       score,
   output logic [7:0]        combo,
   output logic              hit_pulse,
   output logic              miss_pulse,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, MOVE, FETCH, WAIT, SPAWN, JUDGE} state_t;

   localparam logic [Y_W:0] MISS_Y = (Y_W+1)'(HIT_Y + HIT_WIN);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [SLOTS-1:0]  valid_q, valid_d;
   logic [1:0]        lane_q [SLOTS];
   logic [1:0]        lane_d [SLOTS];
   logic [Y_W-1:0]    y_q [SLOTS];
   logic [Y_W-1:0]    y_d [SLOTS];
   logic [PAT_AW-1:0] pat_addr_q, pat_addr_d;
   logic [3:0]        delay_q, delay_d;
   logic [3:0]        pend_q, pend_d;
   logic [3:0]        mask_q, mask_d;
   logic [3:0]        jmask_q, jmask_d;
   logic [3:0]        snap_q, snap_d;
   logic              tick_q, tick_d;
   logic              end_q, end_d;
   logic [15:0]       score_q, score_d;
   logic [7:0]        combo_q, combo_d;
   logic              hit_q, hit_d;
   logic              miss_q, miss_d;

   logic              cur_valid, last, in_win, free_found, to_judge;
   logic [1:0]        cur_lane, lane_sel;
   logic [Y_W:0]      y_ext, y_adv;
   logic [3:0]        low_bit, mask_rest;
   logic [IW-1:0]     free_idx;

   assign cur_valid = valid_q[idx_q];
   assign cur_lane  = lane_q[idx_q];
   assign y_ext     = {1'b0, y_q[idx_q]};
   assign y_adv     = y_ext + (Y_W+1)'(SPEED);
   assign last      = idx_q == IW'(SLOTS-1);
   assign in_win    = (y_ext + (Y_W+1)'(HIT_WIN) >= (Y_W+1)'(HIT_Y)) && (y_ext <= MISS_Y);
   assign low_bit   = mask_q & (~mask_q + 4'd1);
   assign mask_rest = mask_q & ~low_bit;
   assign lane_sel  = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : mask_q[2] ? 2'd2 : 2'd3;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = SLOTS-1; i >= 0; i--)
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      lane_d     = lane_q;
      y_d        = y_q;
      pat_addr_d = pat_addr_q;
      delay_d    = delay_q;
      pend_d     = pend_q | btn;
      mask_d     = mask_q;
      jmask_d    = jmask_q;
      snap_d     = snap_q;
      tick_d     = tick_q | (frame_tick & run);
      end_d      = end_q;
      score_d    = score_q;
      combo_d    = combo_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      to_judge   = 1'b0;
      case (state_q)
         IDLE: begin
            if (run && tick_q) begin
               state_d = MOVE;
               idx_d   = '0;
               tick_d  = frame_tick;
            end else if (pend_q != 4'd0) begin
               to_judge = 1'b1;
            end
         end
         MOVE: begin
            if (cur_valid) begin
               if (y_adv > MISS_Y) begin
                  valid_d[idx_q] = 1'b0;
                  miss_d         = 1'b1;
                  combo_d        = 8'd0;
               end else begin
                  y_d[idx_q] = y_adv[Y_W-1:0];
               end
            end
            idx_d = idx_q + 1'b1;
            if (last) begin
               if (delay_q == 4'd0 && !end_q) begin
                  state_d = FETCH;
               end else begin
                  delay_d  = delay_q - {3'd0, delay_q != 4'd0};
                  to_judge = 1'b1;
               end
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            if (pat_data == 8'h00) begin
               end_d    = 1'b1;
               to_judge = 1'b1;
            end else begin
               mask_d     = pat_data[3:0];
               delay_d    = pat_data[7:4];
               pat_addr_d = pat_addr_q + 1'b1;
               state_d    = SPAWN;
            end
         end
         SPAWN: begin
            if (mask_q == 4'd0) begin
               to_judge = 1'b1;
            end else begin
               mask_d = mask_rest;
               if (free_found) begin
                  valid_d[free_idx] = 1'b1;
                  lane_d[free_idx]  = lane_sel;
                  y_d[free_idx]     = '0;
               end else begin
                  miss_d  = 1'b1;
                  combo_d = 8'd0;
               end
               to_judge = mask_rest == 4'd0;
            end
         end
         JUDGE: begin
            if (cur_valid && jmask_q[cur_lane] && in_win) begin
               valid_d[idx_q]    = 1'b0;
               jmask_d[cur_lane] = 1'b0;
               hit_d             = 1'b1;
               score_d           = score_q > 16'hFFF5 ? 16'hFFFF : score_q + 16'd10;
               combo_d           = combo_q == 8'hFF ? combo_q : combo_q + 8'd1;
            end
            idx_d = idx_q + 1'b1;
            if (last) begin
               pend_d  = (pend_q & ~snap_q) | btn;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // presses latched up to this cycle form the judge set; later ones wait for the next pass
      if (to_judge) begin
         state_d = JUDGE;
         idx_d   = '0;
         snap_d  = pend_q;
         jmask_d = pend_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         valid_q    <= '0;
         pat_addr_q <= '0;
         delay_q    <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         jmask_q    <= '0;
         snap_q     <= '0;
         tick_q     <= 1'b0;
         end_q      <= 1'b0;
         score_q    <= '0;
         combo_q    <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         pat_addr_q <= pat_addr_d;
         delay_q    <= delay_d;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         jmask_q    <= jmask_d;
         snap_q     <= snap_d;
         tick_q     <= tick_d;
         end_q      <= end_d;
         score_q    <= score_d;
         combo_q    <= combo_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
      end
      lane_q <= lane_d;
      y_q    <= y_d;
   end

   assign pat_addr   = pat_addr_q;
   assign rd_valid   = valid_q[rd_idx];
   assign rd_lane    = lane_q[rd_idx];
   assign rd_y       = y_q[rd_idx];
   assign score      = score_q;
   assign combo      = combo_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign done       = end_q && (valid_q == '0);
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed and random frames/presses against a slot-table reference model;
// hit/miss pulses are matched against a scoreboard queue by an independent monitor.
`timescale 1ns/1ps
module tb_note_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1, run = 1'b0, frame_tick = 1'b0;
   logic [3:0] btn = 4'd0;
   logic [5:0] pat_addr;
   logic [7:0] pat_data = 8'd0;
   logic [2:0] rd_idx = 3'd0;
   logic       rd_valid, hit_pulse, miss_pulse, done;
   logic [1:0] rd_lane;
   logic [9:0] rd_y;
   logic [15:0] score;
   logic [7:0] combo;
   logic [7:0] rom [64];

   typedef struct {bit hit; int score; int combo;} ev_t;
   ev_t sb[$];
   ev_t mon_e;
   int  checks = 0, passed = 0, miss_seen = 0;

   bit m_v[8];
   int m_lane[8], m_y[8];
   int m_addr, m_delay, m_score, m_combo;
   bit m_end;

   note_scheduler dut (
      .clk(clk), .rst(rst), .run(run), .frame_tick(frame_tick), .btn(btn),
      .pat_addr(pat_addr), .pat_data(pat_data), .rd_idx(rd_idx), .rd_valid(rd_valid),
      .rd_lane(rd_lane), .rd_y(rd_y), .score(score), .combo(combo),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) pat_data <= rom[pat_addr];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic void push_ev(bit h);
      ev_t e;
      if (h) begin
         m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
         m_combo = (m_combo == 255) ? 255 : m_combo + 1;
      end else begin
         m_combo = 0;
      end
      e.hit = h; e.score = m_score; e.combo = m_combo;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (!rst && (hit_pulse || miss_pulse)) begin
         if (miss_pulse) miss_seen++;
         if (hit_pulse && miss_pulse) check("pulse_overlap", int'(hit_pulse & miss_pulse), 0);
         if (sb.size() == 0) begin
            check("spurious_pulse", int'({hit_pulse, miss_pulse}), 0);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_kind_hit", int'(hit_pulse), int'(mon_e.hit));
            check("pulse_score", int'(score), mon_e.score);
            check("pulse_combo", int'(combo), mon_e.combo);
         end
      end
   end

   task automatic model_frame();
      int d, f;
      for (int i = 0; i < 8; i++)
         if (m_v[i]) begin
            m_y[i] += 4;
            if (m_y[i] > 416) begin m_v[i] = 0; push_ev(0); end
         end
      if (m_delay == 0 && !m_end) begin
         d = int'(rom[m_addr]);
         if (d == 0) m_end = 1;
         else begin
            m_delay = d >> 4;
            m_addr  = (m_addr + 1) % 64;
            for (int l = 0; l < 4; l++)
               if ((d >> l) & 1) begin
                  f = -1;
                  for (int i = 7; i >= 0; i--) if (!m_v[i]) f = i;
                  if (f < 0) push_ev(0);
                  else begin m_v[f] = 1; m_lane[f] = l; m_y[f] = 0; end
               end
         end
      end else if (m_delay > 0) m_delay--;
   endtask

   task automatic model_press(int mask);
      int jm = mask;
      for (int i = 0; i < 8; i++)
         if (m_v[i] && ((jm >> m_lane[i]) & 1) && m_y[i] >= 384 && m_y[i] <= 416) begin
            m_v[i] = 0;
            jm &= ~(1 << m_lane[i]);
            push_ev(1);
         end
   endtask

   task automatic read_slot(int i);
      @(negedge clk);
      rd_idx = 3'(i);
      #1;
   endtask

   task automatic check_table();
      for (int i = 0; i < 8; i++) begin
         read_slot(i);
         check($sformatf("slot%0d_valid", i), int'(rd_valid), int'(m_v[i]));
         if (m_v[i]) begin
            check($sformatf("slot%0d_lane", i), int'(rd_lane), m_lane[i]);
            check($sformatf("slot%0d_y", i), int'(rd_y), m_y[i]);
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1; run = 1'b0; frame_tick = 1'b0; btn = 4'd0;
      sb.delete();
      for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_lane[i] = 0; m_y[i] = 0; end
      m_addr = 0; m_delay = 0; m_end = 0; m_score = 0; m_combo = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_score", int'(score), 0);
      check("rst_combo", int'(combo), 0);
      check("rst_hit", int'(hit_pulse), 0);
      check("rst_miss", int'(miss_pulse), 0);
      check("rst_done", int'(done), 0);
      check("rst_pat_addr", int'(pat_addr), 0);
      check_table();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic tick(bit use_model);
      @(posedge clk);
      #1 frame_tick = 1'b1;
      if (use_model && run) model_frame();
      @(posedge clk);
      #1 frame_tick = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      if (use_model) check("queue_drained_tick", sb.size(), 0);
   endtask

   task automatic press(int mask);
      @(posedge clk);
      #1 btn = 4'(mask);
      model_press(mask);
      @(posedge clk);
      #1 btn = 4'd0;
      repeat (20) @(posedge clk);
      #1;
      check("queue_drained_press", sb.size(), 0);
   endtask

   task automatic load_rom(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
      for (int i = 0; i < 64; i++) rom[i] = 8'h00;
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   initial begin
      int m0;
      load_rom(8'h21, 8'h00, 8'h00, 8'h00);
      // single arrow reaching the target line and hit
      apply_reset();
      run = 1'b1;
      tick(1);
      read_slot(0);
      check("t2_spawn_valid", int'(rd_valid), 1);
      check("t2_spawn_y", int'(rd_y), 0);
      check("t2_spawn_lane", int'(rd_lane), 0);
      repeat (100) tick(1);
      read_slot(0);
      check("t2_y_at_target", int'(rd_y), 400);
      check("t2_done_before_hit", int'(done), 0);
      check("t2_pat_addr_hold", int'(pat_addr), 1);
      press(1);
      check("t2_score", int'(score), 10);
      check("t2_combo", int'(combo), 1);
      check("t2_done", int'(done), 1);
      read_slot(0);
      check("t2_slot_cleared", int'(rd_valid), 0);

      // reset asserted while the table is being advanced
      apply_reset();
      run = 1'b1;
      repeat (5) tick(1);
      check_table();
      @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(posedge clk);
      #1;
      apply_reset();

      // no press: arrow passes the window and is missed
      run = 1'b1;
      repeat (106) tick(1);
      check("t3_combo", int'(combo), 0);
      check("t3_score", int'(score), 0);
      check("t3_done", int'(done), 1);
      read_slot(0);
      check("t3_slot_cleared", int'(rd_valid), 0);

      // chords filling the table, third chord dropped
      load_rom(8'h0F, 8'h0F, 8'h0F, 8'h00);
      apply_reset();
      run = 1'b1;
      tick(1);
      for (int i = 0; i < 8; i++) begin
         read_slot(i);
         check($sformatf("t4_valid%0d", i), int'(rd_valid), int'(i < 4));
         if (i < 4) begin
            check($sformatf("t4_lane%0d", i), int'(rd_lane), i);
            check($sformatf("t4_y%0d", i), int'(rd_y), 0);
         end
      end
      m0 = miss_seen;
      tick(1);
      tick(1);
      check("t5_drop_misses", miss_seen - m0, 4);
      check_table();
      tick(1);
      check("t5_done_with_arrows", int'(done), 0);

      // press outside window is discarded; press during JUDGE is retained
      load_rom(8'hF4, 8'h80, 8'h02, 8'h00);
      apply_reset();
      run = 1'b1;
      repeat (101) tick(1);
      read_slot(0);
      check("t6_lane2_y", int'(rd_y), 400);
      read_slot(1);
      check("t6_lane1_y", int'(rd_y), 300);
      press(2);
      check("t6_no_hit_score", int'(score), 0);
      @(posedge clk);
      #1 btn = 4'd2;
      @(posedge clk);
      #1 btn = 4'd0;
      @(posedge clk);
      @(posedge clk);
      #1 btn = 4'd4;
      model_press(2);
      model_press(4);
      @(posedge clk);
      #1 btn = 4'd0;
      repeat (30) @(posedge clk);
      #1;
      check("t6_retained_score", int'(score), 10);
      check("t6_retained_combo", int'(combo), 1);
      check("t6_queue", sb.size(), 0);
      check_table();

      // random patterns, presses and run toggling
      for (int i = 0; i < 64; i++) rom[i] = {4'($urandom_range(0, 2)), 4'($urandom_range(1, 15))};
      rom[40] = 8'h00;
      apply_reset();
      run = 1'b1;
      for (int f = 0; f < 170; f++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         tick(1);
         if ($urandom_range(0, 1) == 1) press(int'($urandom_range(0, 15)));
         check_table();
      end
      check("rand_score_final", int'(score), m_score);
      check("rand_combo_final", int'(combo), m_combo);
      check("final_queue_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
